mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single SPARC memory port between instruction fetch and data access. It latches the winning requester's address and write data, drives the port for a variable-latency transaction, and returns read data with a one-cycle acknowledge. A watchdog ends stalled transactions with an error. The block sits between the fetch/load-store units and the memory interface. It registers the select that drives the port's operand multiplexers.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between
// instruction fetch and data access. It latches the winner's request, runs a
// variable-latency transaction guarded by a watchdog, then returns read data
// together with a one-cycle acknowledge. Every output is a register.
module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic             req_d,
    input  logic [WIDTH-1:0] addr_d,
    input  logic             we_d,
    input  logic [WIDTH-1:0] wdata_d,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             grant_d,
    output logic             ack_i,
    output logic             ack_d,
    output logic [WIDTH-1:0] rdata,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Watchdog counter is 8 bits wide, enough for the largest legal TIMEOUT.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_nxt;
    logic             last_grant_q, last_grant_nxt;
    logic [7:0]       cnt_q, cnt_nxt;

    logic             mem_en_nxt;
    logic             mem_we_nxt;
    logic [WIDTH-1:0] mem_addr_nxt;
    logic [WIDTH-1:0] mem_wdata_nxt;
    logic             grant_d_nxt;
    logic             ack_i_nxt;
    logic             ack_d_nxt;
    logic [WIDTH-1:0] rdata_nxt;
    logic             err_nxt;
    logic             winner;

    // Round-robin choice: a tie goes to whoever was not served last (1 = data).
    function automatic logic pick_winner(input logic ri, input logic rd,
                                         input logic last);
        logic w;
        if (ri && rd) begin
            w = ~last;
        end else begin
            w = rd;
        end
        return w;
    endfunction

    // State, watchdog and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            grant_d      <= 1'b0;
            ack_i        <= 1'b0;
            ack_d        <= 1'b0;
            rdata        <= '0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            last_grant_q <= last_grant_nxt;
            cnt_q        <= cnt_nxt;
            mem_en       <= mem_en_nxt;
            mem_we       <= mem_we_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_wdata    <= mem_wdata_nxt;
            grant_d      <= grant_d_nxt;
            ack_i        <= ack_i_nxt;
            ack_d        <= ack_d_nxt;
            rdata        <= rdata_nxt;
            err          <= err_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless changed below.
    always_comb begin
        state_nxt      = state_q;
        last_grant_nxt = last_grant_q;
        cnt_nxt        = cnt_q;
        mem_en_nxt     = mem_en;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        grant_d_nxt    = grant_d;
        ack_i_nxt      = 1'b0;
        ack_d_nxt      = 1'b0;
        rdata_nxt      = rdata;
        err_nxt        = err;
        winner         = pick_winner(req_i, req_d, last_grant_q);

        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    grant_d_nxt   = winner;
                    mem_addr_nxt  = winner ? addr_d : addr_i;
                    mem_wdata_nxt = winner ? wdata_d : '0;
                    mem_we_nxt    = winner & we_d;
                    mem_en_nxt    = 1'b1;
                    cnt_nxt       = '0;
                    state_nxt     = BUSY;
                end
            end

            BUSY: begin
                // mem_ready takes priority over a coincident watchdog expiry.
                if (mem_ready) begin
                    if (!mem_we) begin
                        rdata_nxt = mem_rdata;
                    end
                    err_nxt    = 1'b0;
                    ack_i_nxt  = ~grant_d;
                    ack_d_nxt  = grant_d;
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                    state_nxt  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_nxt    = 1'b1;
                    rdata_nxt  = '0;
                    ack_i_nxt  = ~grant_d;
                    ack_d_nxt  = grant_d;
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                    state_nxt  = DONE;
                end else begin
                    cnt_nxt = cnt_q + 8'd1;
                end
            end

            DONE: begin
                // The ack is visible this cycle; remember the owner for the next tie.
                last_grant_nxt = grant_d;
                state_nxt      = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed cases plus random traffic, checked
// against a transaction-level model of arbitration, latency and returned data.
module tb_mem_port_arbiter;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_i, req_d, we_d;
    logic [WIDTH-1:0] addr_i, addr_d, wdata_d;
    logic             mem_en, mem_we, mem_ready;
    logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata, rdata;
    logic             grant_d, ack_i, ack_d, err;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who was served last (1 = data), last returned read data.
    bit               last_served;
    logic [WIDTH-1:0] model_rdata;
    // Outstanding requests held by the requesters until acknowledged.
    bit               pend_i, pend_d, w_d;
    logic [WIDTH-1:0] a_i, a_d, wd_d;
    bit               order_q[$];

    mem_port_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_i(req_i), .addr_i(addr_i),
        .req_d(req_d), .addr_d(addr_d), .we_d(we_d), .wdata_d(wdata_d),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant_d(grant_d), .ack_i(ack_i), .ack_d(ack_d), .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_en"},    mem_en, 0);
        check({tag, ".mem_we"},    mem_we, 0);
        check({tag, ".mem_addr"},  mem_addr, 0);
        check({tag, ".mem_wdata"}, mem_wdata, 0);
        check({tag, ".grant_d"},   grant_d, 0);
        check({tag, ".ack_i"},     ack_i, 0);
        check({tag, ".ack_d"},     ack_d, 0);
        check({tag, ".rdata"},     rdata, 0);
        check({tag, ".err"},       err, 0);
    endtask

    task automatic model_reset();
        last_served = 1'b1;
        model_rdata = '0;
        pend_i = 1'b0;
        pend_d = 1'b0;
        req_i  = 1'b0;
        req_d  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        reset = 1'b0;
    endtask

    task automatic idle_cycle();
        req_i = 1'b0;
        req_d = 1'b0;
        @(negedge clk);
        check("idle.mem_en", mem_en, 0);
        check("idle.ack_i", ack_i, 0);
        check("idle.ack_d", ack_d, 0);
    endtask

    // Runs one transaction from an IDLE cycle (called just after a negedge).
    // lat: BUSY cycle carrying mem_ready (0 = never). rst_at: BUSY cycle in
    // which reset is raised (0 = none). rval: data returned with mem_ready.
    task automatic transact(input int lat, input int rst_at, input logic [WIDTH-1:0] rval);
        bit               win, exp_err, exp_we;
        int               busy_len;
        logic [WIDTH-1:0] exp_addr, exp_wd;
        win      = (pend_i && pend_d) ? ~last_served : pend_d;
        req_i    = pend_i;
        addr_i   = a_i;
        req_d    = pend_d;
        addr_d   = a_d;
        we_d     = w_d;
        wdata_d  = wd_d;
        exp_addr = win ? a_d : a_i;
        exp_we   = win && w_d;
        exp_wd   = win ? wd_d : '0;
        if (lat >= 1 && lat <= TIMEOUT) begin
            busy_len = lat;
            exp_err  = 1'b0;
        end else begin
            busy_len = TIMEOUT;
            exp_err  = 1'b1;
        end
        mem_ready = 1'b0;
        order_q.push_back(win);

        for (int n = 1; n <= busy_len; n++) begin
            @(negedge clk);
            check("busy.mem_en", mem_en, 1);
            check("busy.mem_addr", mem_addr, exp_addr);
            check("busy.mem_we", mem_we, exp_we);
            check("busy.mem_wdata", mem_wdata, exp_wd);
            check("busy.grant_d", grant_d, win);
            check("busy.ack", {ack_i, ack_d}, 0);
            if (n == rst_at) begin
                reset = 1'b1;
                mem_ready = 1'b0;
                @(negedge clk);
                check_all_zero("midrst");
                reset = 1'b0;
                model_reset();
                return;
            end
            mem_ready = (n == lat);
            mem_rdata = (n == lat) ? rval : $urandom;
        end

        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (exp_err) model_rdata = '0;
        else if (!exp_we) model_rdata = rval;
        check("done.mem_en", mem_en, 0);
        check("done.mem_we", mem_we, 0);
        check("done.ack_i", ack_i, !win);
        check("done.ack_d", ack_d, win);
        check("done.err", err, exp_err);
        check("done.rdata", rdata, model_rdata);
        if (win) begin pend_d = 1'b0; req_d = 1'b0; end
        else     begin pend_i = 1'b0; req_i = 1'b0; end
        last_served = win;

        @(negedge clk);
        check("post.ack", {ack_i, ack_d}, 0);
        check("post.mem_en", mem_en, 0);
    endtask

    function automatic int rand_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r == 1) return TIMEOUT;
        return $urandom_range(1, 5);
    endfunction

    initial begin
        reset = 1'b1;
        req_i = 0; req_d = 0; we_d = 0;
        addr_i = '0; addr_d = '0; wdata_d = '0;
        mem_ready = 0; mem_rdata = '0;
        pend_i = 0; pend_d = 0; w_d = 0;
        a_i = '0; a_d = '0; wd_d = '0;

        // Reset, then idle with no requests.
        do_reset(2);
        for (int k = 0; k < 3; k++) idle_cycle();

        // Single fetch read with 3-cycle memory latency.
        pend_i = 1; a_i = 32'h100;
        transact(3, 0, 32'hDEADBEEF);
        check("fetch.rdata_hold", rdata, 32'hDEADBEEF);

        // Data write completing in the first BUSY cycle; rdata must not change.
        pend_d = 1; a_d = 32'h40; w_d = 1; wd_d = 32'h1234;
        transact(1, 0, 32'hCAFEF00D);
        check("write.rdata_kept", rdata, 32'hDEADBEEF);

        // Continuous contention from reset: fetch, data, fetch, data.
        do_reset(1);
        order_q.delete();
        for (int t = 0; t < 4; t++) begin
            pend_i = 1; pend_d = 1; w_d = 0;
            a_i = $urandom; a_d = $urandom;
            transact($urandom_range(1, 4), 0, $urandom);
        end
        for (int t = 0; t < 4; t++) check("contention.order", order_q[t], t % 2);

        // Timeout without mem_ready, then mem_ready in the last allowed cycle.
        pend_i = 1; a_i = 32'h200;
        transact(0, 0, '0);
        pend_d = 1; a_d = 32'h300; w_d = 0;
        transact(TIMEOUT, 0, 32'h5A5A5A5A);

        // Reset during the 2nd BUSY cycle, then a normal request.
        pend_i = 1; a_i = 32'h400;
        transact(0, 2, '0);
        idle_cycle();
        pend_d = 1; a_d = 32'h500; w_d = 0;
        transact(2, 0, 32'h0BADCAFE);

        // Random traffic.
        for (int it = 0; it < 80; it++) begin
            if (!pend_i && $urandom_range(0, 2) != 0) begin
                pend_i = 1; a_i = $urandom;
            end
            if (!pend_d && $urandom_range(0, 2) != 0) begin
                pend_d = 1; a_d = $urandom; w_d = $urandom_range(0, 1); wd_d = $urandom;
            end
            if (pend_i || pend_d) transact(rand_lat(), 0, $urandom);
            else idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
